// File: rtl/us_timer_pkg.sv
// Shared definitions for the microsecond timer controller: register map,
// CTRL bit positions, compare reset value and the address decoder.
package us_timer_pkg;

  localparam logic [4:0] ADDR_NOW_LO = 5'h00;
  localparam logic [4:0] ADDR_NOW_HI = 5'h04;
  localparam logic [4:0] ADDR_CMP_LO = 5'h08;
  localparam logic [4:0] ADDR_CMP_HI = 5'h0C;
  localparam logic [4:0] ADDR_CTRL   = 5'h10;
  localparam logic [4:0] ADDR_STATUS = 5'h14;
  localparam logic [4:0] ADDR_PERIOD = 5'h18;

  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_IRQ_EN   = 1;
  localparam int unsigned CTRL_PERIODIC = 2;

  localparam logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    REG_NOW_LO = 3'd0,
    REG_NOW_HI = 3'd1,
    REG_CMP_LO = 3'd2,
    REG_CMP_HI = 3'd3,
    REG_CTRL   = 3'd4,
    REG_STATUS = 3'd5,
    REG_PERIOD = 3'd6,
    REG_RSVD   = 3'd7
  } reg_sel_e;

  // Byte address to register select; the two low address bits are ignored.
  function automatic reg_sel_e addr_to_reg(input logic [4:0] addr);
    logic [4:0] word;
    reg_sel_e   sel;
    word = {addr[4:2], 2'b00};
    case (word)
      ADDR_NOW_LO: sel = REG_NOW_LO;
      ADDR_NOW_HI: sel = REG_NOW_HI;
      ADDR_CMP_LO: sel = REG_CMP_LO;
      ADDR_CMP_HI: sel = REG_CMP_HI;
      ADDR_CTRL:   sel = REG_CTRL;
      ADDR_STATUS: sel = REG_STATUS;
      ADDR_PERIOD: sel = REG_PERIOD;
      default:     sel = REG_RSVD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/us_prescaler.sv
// Clock-enable prescaler: counts 0..DIV-1 while enabled and flags the wrap
// cycle with tick_o. Disabling pauses the count without clearing it.
module us_prescaler #(
  parameter int unsigned DIV = 100
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned   CW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/us_timer_ctrl.sv
// Memory-mapped 64-bit microsecond timer: prescaled count, 64-bit compare
// with one-shot or periodic re-arm, level interrupt and tear-free reads.
module us_timer_ctrl
  import us_timer_pkg::*;
#(
  parameter int unsigned DIV = 100,
  parameter int unsigned PW  = 32
) (
  input  logic        CLK100MHZ_i,
  input  logic        reset_i,
  input  logic [4:0]  addr_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  input  logic        re_i,
  output logic [31:0] rdata_o,
  output logic [63:0] now_o,
  output logic        tick_o,
  output logic        irq_o
);

  logic [63:0]   now_q,     now_d;
  logic [63:0]   cmp_q,     cmp_d;
  logic [PW-1:0] period_q,  period_d;
  logic [2:0]    ctrl_q,    ctrl_d;
  logic          pending_q, pending_d;
  logic [31:0]   shadow_q,  shadow_d;
  logic [31:0]   rdata_q,   rdata_d;
  logic          irq_q;

  logic          tick_s;
  logic          match_s;
  logic          rearm_s;
  logic [63:0]   period_ext_s;
  reg_sel_e      sel_s;

  us_prescaler #(.DIV(DIV)) u_prescaler (
    .clk_i  (CLK100MHZ_i),
    .rst_i  (reset_i),
    .en_i   (ctrl_q[CTRL_EN]),
    .tick_o (tick_s)
  );

  assign sel_s        = addr_to_reg(addr_i);
  assign period_ext_s = 64'(period_q);
  assign match_s      = ctrl_q[CTRL_EN] && (now_q >= cmp_q);
  // A zero PERIOD degrades periodic mode to one-shot.
  assign rearm_s      = match_s && ctrl_q[CTRL_PERIODIC] && (period_q != '0);

  always_comb begin
    now_d     = tick_s  ? now_q + 64'd1 : now_q;
    cmp_d     = rearm_s ? cmp_q + period_ext_s : cmp_q;
    period_d  = period_q;
    ctrl_d    = ctrl_q;
    pending_d = pending_q;
    if (we_i) begin
      // Software writes override the tick increment and the re-arm for their half.
      case (sel_s)
        REG_NOW_LO: now_d         = {now_q[63:32], wdata_i};
        REG_NOW_HI: now_d         = {wdata_i, now_q[31:0]};
        REG_CMP_LO: cmp_d[31:0]   = wdata_i;
        REG_CMP_HI: cmp_d[63:32]  = wdata_i;
        REG_CTRL:   ctrl_d        = wdata_i[2:0];
        REG_STATUS: pending_d     = wdata_i[0] ? 1'b0 : pending_q;
        REG_PERIOD: period_d      = PW'({32'd0, wdata_i});
        default:    pending_d     = pending_q;
      endcase
    end else begin
      pending_d = pending_q;
    end
    if (match_s) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_d;
    end
  end

  always_comb begin
    rdata_d  = rdata_q;
    shadow_d = shadow_q;
    if (re_i) begin
      // Reading NOW_LO latches the upper half so a following NOW_HI read cannot tear.
      case (sel_s)
        REG_NOW_LO: begin
          rdata_d  = now_q[31:0];
          shadow_d = now_q[63:32];
        end
        REG_NOW_HI: rdata_d = shadow_q;
        REG_CMP_LO: rdata_d = cmp_q[31:0];
        REG_CMP_HI: rdata_d = cmp_q[63:32];
        REG_CTRL:   rdata_d = {29'd0, ctrl_q};
        REG_STATUS: rdata_d = {31'd0, pending_q};
        REG_PERIOD: rdata_d = period_ext_s[31:0];
        default:    rdata_d = 32'd0;
      endcase
    end else begin
      rdata_d = rdata_q;
    end
  end

  always_ff @(posedge CLK100MHZ_i) begin
    if (reset_i) begin
      now_q     <= 64'd0;
      cmp_q     <= CMP_RESET;
      period_q  <= '0;
      ctrl_q    <= 3'd0;
      pending_q <= 1'b0;
      shadow_q  <= 32'd0;
      rdata_q   <= 32'd0;
      irq_q     <= 1'b0;
    end else begin
      now_q     <= now_d;
      cmp_q     <= cmp_d;
      period_q  <= period_d;
      ctrl_q    <= ctrl_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      rdata_q   <= rdata_d;
      irq_q     <= pending_q & ctrl_q[CTRL_IRQ_EN];
    end
  end

  assign rdata_o = rdata_q;
  assign now_o   = now_q;
  assign tick_o  = tick_s;
  assign irq_o   = irq_q;

endmodule
